// File: rtl/max_pool_scheduler_if.sv
// Memory-side bus of the max-pool scheduler: a read port into the feature map
// and a write port with ready/valid backpressure into the pooled output memory.
interface max_pool_scheduler_if #(
  parameter int ADDRWIDTH = 12,
  parameter int BITWIDTH  = 8
);
  logic                 rd_en;
  logic [ADDRWIDTH-1:0] rd_addr;
  logic [BITWIDTH-1:0]  rd_data;
  logic                 wr_en;
  logic [ADDRWIDTH-1:0] wr_addr;
  logic [BITWIDTH-1:0]  wr_data;
  logic                 wr_ready;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output wr_en, wr_addr, wr_data,
    input  wr_ready
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  wr_en, wr_addr, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/max_pool_scheduler.sv
// Sequential max-pool controller: reads one window per pass through READ/DRAIN,
// keeps a running unsigned maximum and writes it out with backpressure.
module max_pool_scheduler #(
  parameter int BITWIDTH    = 8,
  parameter int DATAWIDTH   = 28,
  parameter int DATAHEIGHT  = 28,
  parameter int DATACHANNEL = 3,
  parameter int KWIDTH      = 2,
  parameter int KHEIGHT     = 2,
  parameter int ADDRWIDTH   = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  max_pool_scheduler_if.master   mem_io
);

  localparam int OW = DATAWIDTH / KWIDTH;
  localparam int OH = DATAHEIGHT / KHEIGHT;

  typedef logic [ADDRWIDTH-1:0] addr_t;

  // Counters share the address width so every address product wraps modulo 2**ADDRWIDTH.
  localparam addr_t KX_LAST  = addr_t'(KWIDTH - 1);
  localparam addr_t KY_LAST  = addr_t'(KHEIGHT - 1);
  localparam addr_t OX_LAST  = addr_t'(OW - 1);
  localparam addr_t OY_LAST  = addr_t'(OH - 1);
  localparam addr_t C_LAST   = addr_t'(DATACHANNEL - 1);
  localparam addr_t ROW_IN   = addr_t'(DATAWIDTH);
  localparam addr_t PLANE_IN = addr_t'(DATAHEIGHT * DATAWIDTH);
  localparam addr_t PLANE_OUT= addr_t'(OH * OW);
  localparam addr_t KW_STEP  = addr_t'(KWIDTH);
  localparam addr_t KH_STEP  = addr_t'(KHEIGHT);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_e;

  state_e              state_q, state_d;
  addr_t               kx_q, kx_d, ky_q, ky_d;
  addr_t               ox_q, ox_d, oy_q, oy_d;
  addr_t               c_q, c_d;
  logic [BITWIDTH-1:0] max_q, max_d;
  logic                valid_q, valid_d;
  logic                first_q, first_d;

  addr_t rdAddr;
  addr_t wrAddr;

  assign rdAddr = c_q * PLANE_IN + (oy_q * KH_STEP + ky_q) * ROW_IN + ox_q * KW_STEP + kx_q;
  assign wrAddr = c_q * PLANE_OUT + oy_q * addr_t'(OW) + ox_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      kx_q    <= '0;
      ky_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      c_q     <= '0;
      max_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      c_q     <= c_d;
      max_q   <= max_d;
      valid_q <= valid_d;
      first_q <= first_d;
    end
  end

  // rd_data lags rd_en by one cycle, so valid_q/first_q tag the element arriving now.
  always_comb begin
    state_d = state_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    c_d     = c_q;
    max_d   = max_q;
    valid_d = 1'b0;
    first_d = 1'b0;
    if (valid_q && (first_q || (mem_io.rd_data > max_q))) begin
      max_d = mem_io.rd_data;
    end
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = READ;
          kx_d    = '0;
          ky_d    = '0;
          ox_d    = '0;
          oy_d    = '0;
          c_d     = '0;
        end
      end
      READ: begin
        valid_d = 1'b1;
        first_d = (kx_q == '0) && (ky_q == '0);
        if (kx_q == KX_LAST) begin
          kx_d = '0;
          if (ky_q == KY_LAST) begin
            ky_d    = '0;
            state_d = DRAIN;
          end else begin
            ky_d = ky_q + 1'b1;
          end
        end else begin
          kx_d = kx_q + 1'b1;
        end
      end
      DRAIN: state_d = WRITE;
      WRITE: begin
        if (mem_io.wr_ready) begin
          state_d = READ;
          if (ox_q == OX_LAST) begin
            ox_d = '0;
            if (oy_q == OY_LAST) begin
              oy_d = '0;
              if (c_q == C_LAST) begin
                c_d     = '0;
                state_d = DONE;
              end else begin
                c_d = c_q + 1'b1;
              end
            end else begin
              oy_d = oy_q + 1'b1;
            end
          end else begin
            ox_d = ox_q + 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o         = 1'b0;
    done_o         = 1'b0;
    mem_io.rd_en   = 1'b0;
    mem_io.rd_addr = '0;
    mem_io.wr_en   = 1'b0;
    mem_io.wr_addr = '0;
    mem_io.wr_data = '0;
    case (state_q)
      READ: begin
        busy_o         = 1'b1;
        mem_io.rd_en   = 1'b1;
        mem_io.rd_addr = rdAddr;
      end
      DRAIN: busy_o = 1'b1;
      WRITE: begin
        busy_o         = 1'b1;
        mem_io.wr_en   = 1'b1;
        mem_io.wr_addr = wrAddr;
        mem_io.wr_data = max_q;
      end
      DONE: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_max_pool_scheduler.sv
// Bench for max_pool_scheduler: three instances (4x4x1 2x2, 5x5x2 2x2, 3x2x2 1x1)
// against a window-max reference model computed straight from the map contents.
module tb_max_pool_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  startV;
  logic [2:0]  wrReadyV;
  logic        busyA, busyB, busyC, doneA, doneB, doneC;
  logic [2:0]  busyV, doneV, wrEnV, rdEnV;
  logic [35:0] outsV [3];

  logic [7:0] mem [3][4096];

  int checks, errors, cycleCount;
  int gotAddr [3][64];
  int gotData [3][64];
  int gotN [3];
  int doneCnt [3];
  int doneCyc [3];
  int holdViol [3];
  int overlapViol [3];
  int stallCyc [3];
  int trailRead [3];
  logic prevStall [3];
  int prevAddr [3];
  int prevData [3];
  int expAddr [64];
  int expData [64];
  int expN;

  max_pool_scheduler_if #(.ADDRWIDTH(12), .BITWIDTH(8)) ifA();
  max_pool_scheduler_if #(.ADDRWIDTH(12), .BITWIDTH(8)) ifB();
  max_pool_scheduler_if #(.ADDRWIDTH(12), .BITWIDTH(8)) ifC();

  max_pool_scheduler #(.DATAWIDTH(4), .DATAHEIGHT(4), .DATACHANNEL(1), .KWIDTH(2), .KHEIGHT(2))
    dutA (.clk(clk), .rst(rst), .start_i(startV[0]), .busy_o(busyA), .done_o(doneA), .mem_io(ifA));
  max_pool_scheduler #(.DATAWIDTH(5), .DATAHEIGHT(5), .DATACHANNEL(2), .KWIDTH(2), .KHEIGHT(2))
    dutB (.clk(clk), .rst(rst), .start_i(startV[1]), .busy_o(busyB), .done_o(doneB), .mem_io(ifB));
  max_pool_scheduler #(.DATAWIDTH(3), .DATAHEIGHT(2), .DATACHANNEL(2), .KWIDTH(1), .KHEIGHT(1))
    dutC (.clk(clk), .rst(rst), .start_i(startV[2]), .busy_o(busyC), .done_o(doneC), .mem_io(ifC));

  assign busyV = {busyC, busyB, busyA};
  assign doneV = {doneC, doneB, doneA};
  assign wrEnV = {ifC.wr_en, ifB.wr_en, ifA.wr_en};
  assign rdEnV = {ifC.rd_en, ifB.rd_en, ifA.rd_en};
  assign outsV[0] = {busyA, doneA, ifA.rd_en, ifA.rd_addr, ifA.wr_en, ifA.wr_addr, ifA.wr_data};
  assign outsV[1] = {busyB, doneB, ifB.rd_en, ifB.rd_addr, ifB.wr_en, ifB.wr_addr, ifB.wr_data};
  assign outsV[2] = {busyC, doneC, ifC.rd_en, ifC.rd_addr, ifC.wr_en, ifC.wr_addr, ifC.wr_data};
  assign ifA.wr_ready = wrReadyV[0];
  assign ifB.wr_ready = wrReadyV[1];
  assign ifC.wr_ready = wrReadyV[2];

  // Single-port memories: data appears one cycle after the read strobe, garbage otherwise.
  always @(posedge clk) begin
    ifA.rd_data <= ifA.rd_en ? mem[0][ifA.rd_addr] : 8'($urandom);
    ifB.rd_data <= ifB.rd_en ? mem[1][ifB.rd_addr] : 8'($urandom);
    ifC.rd_data <= ifC.rd_en ? mem[2][ifC.rd_addr] : 8'($urandom);
  end

  task automatic monitorStep(input int k, input logic wrEn, input logic wrRdy, input int wrAddr,
                             input int wrData, input logic rdEn, input int rdAddr, input logic done,
                             input int w, input int h, input int kw, input int kh);
    if (rst) begin
      prevStall[k] = 1'b0;
      return;
    end
    if (prevStall[k] && (!wrEn || wrAddr != prevAddr[k] || wrData != prevData[k])) holdViol[k]++;
    prevStall[k] = wrEn && !wrRdy;
    prevAddr[k]  = wrAddr;
    prevData[k]  = wrData;
    if (wrEn && rdEn) overlapViol[k]++;
    if (wrEn && !wrRdy) stallCyc[k]++;
    if (wrEn && wrRdy && gotN[k] < 64) begin
      gotAddr[k][gotN[k]] = wrAddr;
      gotData[k][gotN[k]] = wrData;
      gotN[k]++;
    end
    if (rdEn && ((((rdAddr % (w * h)) / w) >= (h / kh) * kh) || ((rdAddr % w) >= (w / kw) * kw)))
      trailRead[k]++;
    if (done) begin
      doneCnt[k]++;
      doneCyc[k] = cycleCount;
    end
  endtask

  always @(negedge clk) begin
    cycleCount++;
    monitorStep(0, ifA.wr_en, ifA.wr_ready, int'(ifA.wr_addr), int'(ifA.wr_data), ifA.rd_en,
                int'(ifA.rd_addr), doneA, 4, 4, 2, 2);
    monitorStep(1, ifB.wr_en, ifB.wr_ready, int'(ifB.wr_addr), int'(ifB.wr_data), ifB.rd_en,
                int'(ifB.rd_addr), doneB, 5, 5, 2, 2);
    monitorStep(2, ifC.wr_en, ifC.wr_ready, int'(ifC.wr_addr), int'(ifC.wr_data), ifC.rd_en,
                int'(ifC.rd_addr), doneC, 3, 2, 1, 1);
  end

  // Reference: every stride-aligned window's unsigned maximum, channel-major, row-major.
  task automatic buildModel(input int k, input int w, input int h, input int c, input int kw, input int kh);
    int ow = w / kw;
    int oh = h / kh;
    expN = 0;
    for (int ch = 0; ch < c; ch++)
      for (int oy = 0; oy < oh; oy++)
        for (int ox = 0; ox < ow; ox++) begin
          int m = 0;
          for (int ky = 0; ky < kh; ky++)
            for (int kx = 0; kx < kw; kx++) begin
              int v = int'(mem[k][(ch * h * w + (oy * kh + ky) * w + ox * kw + kx) % 4096]);
              if (v > m) m = v;
            end
          expAddr[expN] = (ch * oh * ow + oy * ow + ox) % 4096;
          expData[expN] = m;
          expN++;
        end
  endtask

  task automatic fillRandom(input int k);
    for (int i = 0; i < 64; i++) mem[k][i] = 8'($urandom);
  endtask

  task automatic clearStats(input int k);
    gotN[k] = 0;
    holdViol[k] = 0;
    overlapViol[k] = 0;
    stallCyc[k] = 0;
    trailRead[k] = 0;
    for (int i = 0; i < 64; i++) begin
      gotAddr[k][i] = -1;
      gotData[k][i] = -1;
    end
  endtask

  // readyMode 0: always ready; 1: ten-cycle stall on write stallIdx; 2: random ready.
  task automatic applyStimulus(input int k, input int readyMode, input int stallIdx, input bit noise,
                               output int latency, output bit timedOut);
    int s;
    int stallLeft = 0;
    bit stalled = 0;
    clearStats(k);
    latency  = -1;
    timedOut = 1'b1;
    @(posedge clk); #1;
    startV[k]   = 1'b1;
    wrReadyV[k] = 1'b1;
    s = cycleCount + 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      startV[k] = noise && busyV[k] && (cyc % 5 == 2);
      if (readyMode == 1) begin
        if (stallLeft > 0) begin
          stallLeft--;
          if (stallLeft == 0) wrReadyV[k] = 1'b1;
        end else if (!stalled && gotN[k] == stallIdx && wrEnV[k]) begin
          wrReadyV[k] = 1'b0;
          stallLeft = 10;
          stalled = 1'b1;
        end
      end else if (readyMode == 2) begin
        wrReadyV[k] = ($urandom_range(0, 3) != 0);
      end
      if (doneV[k]) begin
        if (noise) startV[k] = 1'b1;
        @(posedge clk); #1;
        startV[k] = 1'b0;
        timedOut = 1'b0;
        latency = doneCyc[k] - s + 1;
        break;
      end
    end
    startV[k]   = 1'b0;
    wrReadyV[k] = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (outsV[k] !== 36'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs%0d got %h want 0", k, outsV[k]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (outsV[k] !== 36'd0) begin
        errors++;
        $display("[TB] FAIL idle_outputs%0d got %h want 0", k, outsV[k]);
      end
    end
  endtask

  task automatic test_basic();
    int lat; bit to; int d0;
    for (int i = 0; i < 16; i++) mem[0][i] = 8'(i);
    buildModel(0, 4, 4, 1, 2, 2);
    d0 = doneCnt[0];
    applyStimulus(0, 0, 0, 1'b0, lat, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL basic_timeout got timeout want done"); end
    checks++;
    if (gotN[0] !== expN) begin errors++; $display("[TB] FAIL basic_count got %0d want %0d", gotN[0], expN); end
    for (int i = 0; i < expN; i++) begin
      checks++;
      if (gotAddr[0][i] !== expAddr[i] || gotData[0][i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL basic_write%0d got %0d/%0d want %0d/%0d", i, gotAddr[0][i], gotData[0][i], expAddr[i], expData[i]);
      end
    end
    checks++;
    if (lat !== 1 + 4 * 6 + 1) begin errors++; $display("[TB] FAIL basic_latency got %0d want %0d", lat, 26); end
    repeat (4) @(negedge clk);
    checks++;
    if (doneCnt[0] - d0 !== 1) begin errors++; $display("[TB] FAIL basic_done_pulses got %0d want 1", doneCnt[0] - d0); end
    checks++;
    if (overlapViol[0] !== 0) begin errors++; $display("[TB] FAIL basic_rd_wr_overlap got %0d want 0", overlapViol[0]); end
  endtask

  task automatic test_unsigned();
    int lat; bit to;
    fillRandom(0);
    mem[0][0] = 8'd200; mem[0][1] = 8'd255; mem[0][4] = 8'd0; mem[0][5] = 8'd254;
    mem[0][2] = 8'd0;   mem[0][3] = 8'd0;   mem[0][6] = 8'd0; mem[0][7] = 8'd0;
    buildModel(0, 4, 4, 1, 2, 2);
    applyStimulus(0, 0, 0, 1'b0, lat, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL unsigned_timeout got timeout want done"); end
    checks++;
    if (gotData[0][0] !== 255) begin errors++; $display("[TB] FAIL unsigned_max got %0d want 255", gotData[0][0]); end
    checks++;
    if (gotData[0][1] !== 0) begin errors++; $display("[TB] FAIL zero_window got %0d want 0", gotData[0][1]); end
    for (int i = 0; i < expN; i++) begin
      checks++;
      if (gotAddr[0][i] !== expAddr[i] || gotData[0][i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL unsigned_write%0d got %0d/%0d want %0d/%0d", i, gotAddr[0][i], gotData[0][i], expAddr[i], expData[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    fillRandom(0);
    buildModel(0, 4, 4, 1, 2, 2);
    applyStimulus(0, 1, 1, 1'b0, lat, to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL stall_timeout got timeout want done"); end
    checks++;
    if (lat !== 26 + 10) begin errors++; $display("[TB] FAIL stall_latency got %0d want 36", lat); end
    checks++;
    if (stallCyc[0] !== 10) begin errors++; $display("[TB] FAIL stall_cycles got %0d want 10", stallCyc[0]); end
    checks++;
    if (holdViol[0] !== 0) begin errors++; $display("[TB] FAIL stall_hold got %0d changes want 0", holdViol[0]); end
    checks++;
    if (overlapViol[0] !== 0) begin errors++; $display("[TB] FAIL stall_rd_en got %0d want 0", overlapViol[0]); end
    for (int i = 0; i < expN; i++) begin
      checks++;
      if (gotAddr[0][i] !== expAddr[i] || gotData[0][i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL stall_write%0d got %0d/%0d want %0d/%0d", i, gotAddr[0][i], gotData[0][i], expAddr[i], expData[i]);
      end
    end
  endtask

  task automatic test_reset_midpass();
    int lat; bit to; int d0; bit hit = 1'b0;
    fillRandom(0);
    clearStats(0);
    d0 = doneCnt[0];
    @(posedge clk); #1;
    startV[0] = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk); #1;
      startV[0] = 1'b0;
      if (gotN[0] == 2 && rdEnV[0]) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("[TB] FAIL midreset_reach got timeout want window 3 read"); end
    rst = 1'b1;
    #1;
    checks++;
    if (outsV[0] !== 36'd0) begin errors++; $display("[TB] FAIL midreset_outputs got %h want 0", outsV[0]); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (doneCnt[0] !== d0 || gotN[0] !== 2) begin
      errors++;
      $display("[TB] FAIL midreset_abort got done %0d writes %0d want done 0 writes 2", doneCnt[0] - d0, gotN[0]);
    end
    buildModel(0, 4, 4, 1, 2, 2);
    applyStimulus(0, 0, 0, 1'b0, lat, to);
    checks++;
    if (to || lat !== 26) begin errors++; $display("[TB] FAIL midreset_rerun_latency got %0d want 26", lat); end
    for (int i = 0; i < expN; i++) begin
      checks++;
      if (gotAddr[0][i] !== expAddr[i] || gotData[0][i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL midreset_write%0d got %0d/%0d want %0d/%0d", i, gotAddr[0][i], gotData[0][i], expAddr[i], expData[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat; bit to; int d0;
    fillRandom(0);
    buildModel(0, 4, 4, 1, 2, 2);
    d0 = doneCnt[0];
    applyStimulus(0, 0, 0, 1'b1, lat, to);
    repeat (5) @(negedge clk);
    checks++;
    if (to || doneCnt[0] - d0 !== 1) begin errors++; $display("[TB] FAIL noise_done_pulses got %0d want 1", doneCnt[0] - d0); end
    checks++;
    if (lat !== 26) begin errors++; $display("[TB] FAIL noise_latency got %0d want 26", lat); end
    checks++;
    if (busyV[0] !== 1'b0 || gotN[0] !== expN) begin
      errors++;
      $display("[TB] FAIL noise_single_pass got busy %0b writes %0d want busy 0 writes %0d", busyV[0], gotN[0], expN);
    end
    for (int i = 0; i < expN; i++) begin
      checks++;
      if (gotAddr[0][i] !== expAddr[i] || gotData[0][i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL noise_write%0d got %0d/%0d want %0d/%0d", i, gotAddr[0][i], gotData[0][i], expAddr[i], expData[i]);
      end
    end
  endtask

  task automatic test_trailing();
    int lat; bit to;
    fillRandom(1);
    buildModel(1, 5, 5, 2, 2, 2);
    applyStimulus(1, 0, 0, 1'b0, lat, to);
    checks++;
    if (to || lat !== 1 + 8 * 6 + 1) begin errors++; $display("[TB] FAIL trail_latency got %0d want 50", lat); end
    checks++;
    if (gotN[1] !== 8) begin errors++; $display("[TB] FAIL trail_count got %0d want 8", gotN[1]); end
    checks++;
    if (trailRead[1] !== 0) begin errors++; $display("[TB] FAIL trail_reads got %0d want 0", trailRead[1]); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gotAddr[1][4 + i] !== 4 + i) begin
        errors++;
        $display("[TB] FAIL trail_ch1_addr%0d got %0d want %0d", i, gotAddr[1][4 + i], 4 + i);
      end
    end
    for (int i = 0; i < expN; i++) begin
      checks++;
      if (gotAddr[1][i] !== expAddr[i] || gotData[1][i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL trail_write%0d got %0d/%0d want %0d/%0d", i, gotAddr[1][i], gotData[1][i], expAddr[i], expData[i]);
      end
    end
  endtask

  task automatic test_copy_random_ready();
    int lat; bit to;
    for (int rep = 0; rep < 3; rep++) begin
      fillRandom(2);
      buildModel(2, 3, 2, 2, 1, 1);
      applyStimulus(2, 2, 0, 1'b0, lat, to);
      checks++;
      if (to || gotN[2] !== expN) begin errors++; $display("[TB] FAIL copy_count%0d got %0d want %0d", rep, gotN[2], expN); end
      checks++;
      if (holdViol[2] !== 0 || overlapViol[2] !== 0) begin
        errors++;
        $display("[TB] FAIL copy_protocol%0d got hold %0d overlap %0d want 0 0", rep, holdViol[2], overlapViol[2]);
      end
      for (int i = 0; i < expN; i++) begin
        checks++;
        if (gotAddr[2][i] !== expAddr[i] || gotData[2][i] !== expData[i]) begin
          errors++;
          $display("[TB] FAIL copy%0d_write%0d got %0d/%0d want %0d/%0d", rep, i, gotAddr[2][i], gotData[2][i], expAddr[i], expData[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    startV = '0;
    wrReadyV = '1;
    checks = 0;
    errors = 0;
    cycleCount = 0;
    for (int k = 0; k < 3; k++) begin
      doneCnt[k] = 0;
      doneCyc[k] = 0;
      prevStall[k] = 1'b0;
      prevAddr[k] = 0;
      prevData[k] = 0;
      clearStats(k);
      for (int i = 0; i < 4096; i++) mem[k][i] = 8'd0;
    end
    test_reset();
    test_basic();
    test_unsigned();
    test_backpressure();
    test_reset_midpass();
    test_start_ignored();
    test_trailing();
    test_copy_random_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
